// File: rtl/find_stars_pkg.sv
// Shared constants and types for the star-finding frame path.
// Frame geometry, pixel encoding and the scanner state machine live here.
package find_stars_pkg;

    localparam int unsigned WIDTH  = 160;
    localparam int unsigned HEIGHT = 120;
    localparam int unsigned XSZ    = 8;
    localparam int unsigned YSZ    = 7;
    localparam int unsigned ADDR_W = 15;
    localparam int unsigned COL_W  = 3;

    localparam logic [COL_W-1:0]  BG_COLOUR = 3'b000;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        FOUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    // One issued read travelling alongside the memory latency.
    typedef struct packed {
        logic              valid;
        logic [XSZ-1:0]    x;
        logic [YSZ-1:0]    y;
        logic [ADDR_W-1:0] addr;
    } pix_t;

    function automatic logic row_end(input logic [XSZ-1:0] x);
        return x == XSZ'(WIDTH - 1);
    endfunction

    function automatic logic last_row(input logic [YSZ-1:0] y);
        return y == YSZ'(HEIGHT - 1);
    endfunction

endpackage

// File: rtl/raster_counter.sv
// Raster-order x/y/address counter with row wrap and end-of-frame flag.
// The load port reloads the successor of a given position.
module raster_counter
    import find_stars_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              step,
    input  logic              load,
    input  logic [XSZ-1:0]    ld_x,
    input  logic [YSZ-1:0]    ld_y,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic [XSZ-1:0]    x,
    output logic [YSZ-1:0]    y,
    output logic [ADDR_W-1:0] addr,
    output logic              eof
);

    logic [XSZ-1:0]    x_q, x_d, src_x;
    logic [YSZ-1:0]    y_q, y_d, src_y;
    logic [ADDR_W-1:0] addr_q, addr_d, src_addr;
    logic              eof_q, eof_d;
    logic              at_row_end;
    logic              at_last;

    always_comb begin
        src_x      = load ? ld_x    : x_q;
        src_y      = load ? ld_y    : y_q;
        src_addr   = load ? ld_addr : addr_q;
        at_row_end = row_end(src_x);
        at_last    = at_row_end && last_row(src_y);

        x_d    = x_q;
        y_d    = y_q;
        addr_d = addr_q;
        eof_d  = eof_q;

        if (clear) begin
            x_d    = '0;
            y_d    = '0;
            addr_d = '0;
            eof_d  = 1'b0;
        end else if (load || (step && !eof_q)) begin
            // The last pixel has no successor: park on it and flag end of frame.
            if (at_last) begin
                x_d    = src_x;
                y_d    = src_y;
                addr_d = src_addr;
                eof_d  = 1'b1;
            end else begin
                x_d    = at_row_end ? '0 : src_x + 1'b1;
                y_d    = at_row_end ? src_y + 1'b1 : src_y;
                addr_d = src_addr + 1'b1;
                eof_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q    <= '0;
            y_q    <= '0;
            addr_q <= '0;
            eof_q  <= 1'b0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            addr_q <= addr_d;
            eof_q  <= eof_d;
        end
    end

    assign x    = x_q;
    assign y    = y_q;
    assign addr = addr_q;
    assign eof  = eof_q;

endmodule

// File: rtl/frame_scanner.sv
// Scans the star frame memory in raster order and reports each non-background
// pixel as a held hit until the consumer acknowledges it with resume.
module frame_scanner
    import find_stars_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              go,
    input  logic              resume,
    output logic [ADDR_W-1:0] rdAddr,
    input  logic [COL_W-1:0]  rdData,
    output logic [XSZ-1:0]    xOut,
    output logic [YSZ-1:0]    yOut,
    output logic              starFound,
    output logic              busy,
    output logic              done
);

    state_t            state_q, state_d;
    pix_t              shadow_q, shadow_d;
    logic [XSZ-1:0]    x_out_q, x_out_d;
    logic [YSZ-1:0]    y_out_q, y_out_d;

    logic [XSZ-1:0]    cnt_x;
    logic [YSZ-1:0]    cnt_y;
    logic [ADDR_W-1:0] cnt_addr;
    logic              cnt_eof;
    logic              cnt_clear, cnt_step, cnt_load;
    logic              scanning, hit, frame_end;

    raster_counter u_raster_counter (
        .clk     (clk),
        .reset   (reset),
        .clear   (cnt_clear),
        .step    (cnt_step),
        .load    (cnt_load),
        .ld_x    (shadow_q.x),
        .ld_y    (shadow_q.y),
        .ld_addr (shadow_q.addr),
        .x       (cnt_x),
        .y       (cnt_y),
        .addr    (cnt_addr),
        .eof     (cnt_eof)
    );

    always_comb begin
        scanning  = (state_q == SCAN);
        hit       = scanning && shadow_q.valid && (rdData != BG_COLOUR);
        frame_end = scanning && shadow_q.valid && !hit && (shadow_q.addr == LAST_ADDR);

        cnt_clear = (state_q == IDLE) && go;
        cnt_step  = scanning && !hit && !cnt_eof;
        // The read already in flight on a hit is dropped; the counter is
        // rewound to the pixel after the hit so it is reissued on resume.
        cnt_load  = hit;

        shadow_d.valid = cnt_step;
        shadow_d.x     = cnt_x;
        shadow_d.y     = cnt_y;
        shadow_d.addr  = cnt_addr;

        x_out_d = hit ? shadow_q.x : x_out_q;
        y_out_d = hit ? shadow_q.y : y_out_q;

        state_d = state_q;
        case (state_q)
            IDLE:    if (go) state_d = SCAN;
            SCAN: begin
                if (hit)            state_d = FOUND;
                else if (frame_end) state_d = DONE;
            end
            FOUND:   if (resume) state_d = cnt_eof ? DONE : SCAN;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            x_out_q  <= '0;
            y_out_q  <= '0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            x_out_q  <= x_out_d;
            y_out_q  <= y_out_d;
        end
    end

    assign rdAddr    = cnt_addr;
    assign xOut      = x_out_q;
    assign yOut      = y_out_q;
    assign starFound = (state_q == FOUND);
    assign busy      = (state_q == SCAN) || (state_q == FOUND);
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_frame_scanner.sv
// Self-checking bench for frame_scanner: behavioural pixel memory, expected
// hits queued as stars are planted and popped as the DUT reports them.
module tb_frame_scanner;
    import find_stars_pkg::*;

    localparam int unsigned NPIX = WIDTH * HEIGHT;

    logic              clk = 1'b0;
    logic              reset;
    logic              go;
    logic              resume;
    logic [ADDR_W-1:0] rdAddr;
    logic [COL_W-1:0]  rdData;
    logic [XSZ-1:0]    xOut;
    logic [YSZ-1:0]    yOut;
    logic              starFound;
    logic              busy;
    logic              done;

    logic [COL_W-1:0]  mem [NPIX];

    typedef struct {
        int unsigned x;
        int unsigned y;
    } hit_t;

    hit_t        exp_q[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    int unsigned r_done_cyc, r_last_found, r_hits;
    int unsigned r_addr_bad, r_busy_bad, r_hold_bad;
    bit          r_stopped;

    frame_scanner dut (
        .clk       (clk),
        .reset     (reset),
        .go        (go),
        .resume    (resume),
        .rdAddr    (rdAddr),
        .rdData    (rdData),
        .xOut      (xOut),
        .yOut      (yOut),
        .starFound (starFound),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rdData <= mem[rdAddr];

    task automatic check_val(input string tag, input int unsigned got, input int unsigned want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    endtask

    task automatic clear_frame();
        for (int i = 0; i < int'(NPIX); i++) mem[i] = '0;
    endtask

    task automatic set_star(input int unsigned x, input int unsigned y);
        hit_t h;
        mem[y * WIDTH + x] = 3'b110;
        h.x = x;
        h.y = y;
        exp_q.push_back(h);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_val({tag, "_rdAddr"}, rdAddr, 0);
        check_val({tag, "_xOut"}, xOut, 0);
        check_val({tag, "_yOut"}, yOut, 0);
        check_val({tag, "_starFound"}, starFound, 0);
        check_val({tag, "_busy"}, busy, 0);
        check_val({tag, "_done"}, done, 0);
    endtask

    // Pulses go and follows the scan one sampled cycle at a time (cycle 1 is
    // the first cycle after the go edge). Optional early stop at an address
    // or at the first hit, for the reset scenarios.
    task automatic run_frame(input bit hold_res, input int unsigned res_wait,
                             input int unsigned glitch_cyc, input int unsigned stop_addr,
                             input bit stop_in_found);
        int unsigned exp_addr;
        int unsigned found_len;
        bit          issued_all, prev_found, hit_last, known;
        hit_t        h;
        r_done_cyc = 0; r_last_found = 0; r_hits = 0;
        r_addr_bad = 0; r_busy_bad = 0; r_hold_bad = 0; r_stopped = 0;
        exp_addr = 0; found_len = 0;
        issued_all = 0; prev_found = 0; hit_last = 0; known = 0;
        h.x = 0; h.y = 0;

        @(negedge clk);
        go = 1'b1;
        resume = hold_res;
        @(negedge clk);
        go = 1'b0;
        for (int unsigned cyc = 1; cyc <= 40000; cyc++) begin
            if (cyc > 1) @(negedge clk);
            go = 1'b0;
            resume = hold_res;
            if (done) begin
                r_done_cyc = cyc;
                check_val("busy_at_done", busy, 0);
                break;
            end
            if (!busy) r_busy_bad++;
            if (starFound) begin
                if (!prev_found) begin
                    r_hits++;
                    found_len = 0;
                    if (exp_q.size() == 0) begin
                        check_val("unexpected_hit", 1, 0);
                        known = 0;
                        hit_last = 1;
                    end else begin
                        h = exp_q.pop_front();
                        known = 1;
                        check_val("hit_x", xOut, h.x);
                        check_val("hit_y", yOut, h.y);
                        hit_last = (h.x == WIDTH - 1) && (h.y == HEIGHT - 1);
                        if (!hit_last) begin
                            exp_addr = h.y * WIDTH + h.x + 1;
                            issued_all = 0;
                            check_val("found_addr", rdAddr, exp_addr);
                        end
                    end
                    if (stop_in_found) begin
                        r_stopped = 1;
                        break;
                    end
                end
                found_len++;
                r_last_found = cyc;
                if (!hit_last && rdAddr != exp_addr) r_addr_bad++;
                if (known && (xOut != h.x || yOut != h.y)) r_hold_bad++;
                if (found_len > res_wait) resume = 1'b1;
            end else begin
                if (prev_found) check_val("found_len", found_len, hold_res ? 1 : res_wait + 1);
                if (!issued_all) begin
                    if (rdAddr != exp_addr) r_addr_bad++;
                    if (exp_addr == NPIX - 1) issued_all = 1;
                    else exp_addr++;
                end
                if (stop_addr != 0 && rdAddr == stop_addr) begin
                    r_stopped = 1;
                    break;
                end
                if (cyc == glitch_cyc) go = 1'b1;
                if (cyc == glitch_cyc + 5) resume = 1'b1;
            end
            prev_found = starFound;
        end
        go = 1'b0;
        resume = 1'b0;
        if (!r_stopped && r_done_cyc == 0) check_val("done_timeout", 0, 1);
    endtask

    initial begin
        reset  = 1'b1;
        go     = 1'b0;
        resume = 1'b0;
        clear_frame();
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        reset = 1'b0;

        // Empty frame
        run_frame(0, 0, 0, 0, 0);
        check_val("empty_done_cycle", r_done_cyc, 19202);
        check_val("empty_hits", r_hits, 0);
        check_val("empty_addr_seq", r_addr_bad, 0);
        check_val("empty_busy", r_busy_bad, 0);

        // Single star, delayed resume, stray go/resume while scanning
        clear_frame();
        set_star(37, 52);
        run_frame(0, 3, 100, 0, 0);
        check_val("single_hits", r_hits, 1);
        check_val("single_left", exp_q.size(), 0);
        check_val("single_addr_seq", r_addr_bad, 0);
        check_val("single_busy", r_busy_bad, 0);
        check_val("single_hold", r_hold_bad, 0);

        // Adjacent pair, end-of-row and corner, resume held high throughout
        clear_frame();
        set_star(5, 5);
        set_star(6, 5);
        set_star(159, 10);
        set_star(159, 119);
        run_frame(1, 0, 0, 0, 0);
        check_val("multi_hits", r_hits, 4);
        check_val("multi_left", exp_q.size(), 0);
        check_val("multi_addr_seq", r_addr_bad, 0);
        check_val("multi_busy", r_busy_bad, 0);
        check_val("multi_hold", r_hold_bad, 0);
        check_val("corner_done", r_done_cyc, r_last_found + 1);

        // Reset mid-scan with a star in flight, then restart from 0
        clear_frame();
        mem[4999] = 3'b001;
        run_frame(0, 0, 0, 5000, 0);
        check_val("mid_reached_5000", r_stopped, 1);
        reset = 1'b1;
        @(negedge clk);
        check_outputs_zero("mid_reset");
        reset = 1'b0;
        mem[4999] = '0;
        run_frame(0, 0, 0, 20, 0);
        check_val("mid_restart_stop", r_stopped, 1);
        check_val("mid_restart_seq", r_addr_bad, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        // Reset while a hit is held, then restart from 0
        clear_frame();
        set_star(3, 1);
        run_frame(0, 0, 0, 0, 1);
        check_val("found_stop", r_stopped, 1);
        reset = 1'b1;
        @(negedge clk);
        check_outputs_zero("found_reset");
        reset = 1'b0;
        run_frame(0, 0, 0, 10, 0);
        check_val("found_restart_stop", r_stopped, 1);
        check_val("found_restart_seq", r_addr_bad, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
